// File: rtl/cache_responder.sv
// -----------------------------------------------------------------------------
// cache_responder
//
// Direct-mapped, read-only, one-word-per-line cache. It answers one request at
// a time with hit/miss status and data. On a miss it fetches the word from a
// backing memory over a simple req/ack handshake and fills the line. Saturating
// access and miss counters let a bench read the miss rate directly.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   req_valid      initiator presents an address
//   req_ready      block accepts a request (high only while idle)
//   address        byte address of the request
//   resp_valid     one-cycle pulse, hit/dataOut are valid
//   hit            response was a cache hit (held until the next response)
//   dataOut        response word (held until the next response)
//   mem_req        fill request to backing memory
//   mem_addr       word-aligned fill address (zero when no fill is pending)
//   mem_ack        backing memory returns data this cycle
//   mem_rdata      fill data, sampled when mem_ack is high during a fill
//   access_count   completed responses (saturating)
//   miss_count     completed miss responses (saturating)
// -----------------------------------------------------------------------------
module cache_responder #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] address,
    output logic              resp_valid,
    output logic              hit,
    output logic [DATA_W-1:0] dataOut,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  access_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int WORD_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;      // registered word address
    logic                hit_q, hit_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    miss_q, miss_d;
    logic [LINES-1:0]    valid_q, valid_d;

    // Tag and data storage: no reset, the valid bits alone qualify a line.
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [DATA_W-1:0]   data_mem [LINES];
    logic [TAG_W-1:0]    rd_tag_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                fill_we;

    logic [INDEX_W-1:0]  idx_q;
    logic [TAG_W-1:0]    tag_q;
    logic [INDEX_W-1:0]  req_idx;
    logic                unused_offset;

    assign idx_q   = word_q[INDEX_W-1:0];
    assign tag_q   = word_q[WORD_W-1:INDEX_W];
    assign req_idx = address[INDEX_W+1:2];

    // Byte offset within the word plays no part in the lookup.
    assign unused_offset = ^address[1:0];

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            hit_q   <= 1'b0;
            data_q  <= '0;
            acc_q   <= '0;
            miss_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            hit_q   <= hit_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            miss_q  <= miss_d;
            valid_q <= valid_d;
        end
    end

    // Line storage with a registered read. The read is launched on the accept
    // edge so the stored tag/data are ready for the single LOOKUP cycle. A fill
    // always completes at least two edges before the next accept, so the read
    // never races a write to the same line.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[idx_q]  <= tag_q;
            data_mem[idx_q] <= mem_rdata;
        end
        if (state_q == IDLE && req_valid) begin
            rd_tag_q  <= tag_mem[req_idx];
            rd_data_q <= data_mem[req_idx];
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        hit_d   = hit_q;
        data_d  = data_q;
        acc_d   = acc_q;
        miss_d  = miss_q;
        valid_d = valid_q;
        fill_we = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    word_d  = address[ADDR_W-1:2];
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (valid_q[idx_q] && (rd_tag_q == tag_q)) begin
                    hit_d   = 1'b1;
                    data_d  = rd_data_q;
                    state_d = RESP;
                end else begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    fill_we        = 1'b1;
                    valid_d[idx_q] = 1'b1;
                    hit_d          = 1'b0;
                    data_d         = mem_rdata;
                    state_d        = RESP;
                end
            end
            RESP: begin
                // Counters stick at all-ones instead of wrapping.
                if (acc_q != '1) begin
                    acc_d = acc_q + CNT_W'(1);
                end
                if (!hit_q && (miss_q != '1)) begin
                    miss_d = miss_q + CNT_W'(1);
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from registered state so reset reaches them
    // without waiting for a clock edge.
    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RESP);
    assign mem_req      = (state_q == FILL);
    assign mem_addr     = mem_req ? {word_q, 2'b00} : '0;
    assign hit          = hit_q;
    assign dataOut      = data_q;
    assign access_count = acc_q;
    assign miss_count   = miss_q;

endmodule

// File: tb/tb_cache_responder.sv
module tb_cache_responder;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] address = '0;
    logic        resp_valid;
    logic        hit;
    logic [31:0] dataOut;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [CNT_W-1:0] access_count;
    logic [CNT_W-1:0] miss_count;

    int tests = 0;
    int fails = 0;

    cache_responder #(
        .ADDR_W(32), .DATA_W(32), .INDEX_W(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .address(address),
        .resp_valid(resp_valid), .hit(hit), .dataOut(dataOut),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .access_count(access_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Cache contents as an array of lines keyed by address bits, plus
    // saturating integer counters.
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    int          m_acc;
    int          m_miss;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_acc  = 0;
        m_miss = 0;
    endtask

    task automatic model_access(input logic [31:0] a, input logic [31:0] rd,
                                output logic eh, output logic [31:0] ed);
        int i;
        i  = int'(a[5:2]);
        eh = m_valid[i] && (m_tag[i] == a[31:6]);
        if (!eh) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = a[31:6];
            m_data[i]  = rd;
        end
        ed = m_data[i];
        if (m_acc < CMAX) m_acc++;
        if (!eh && m_miss < CMAX) m_miss++;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one request and drive the backing memory. dly is the number of
    // FILL cycles before mem_ack rises (0 = ack in the first mem_req cycle).
    task automatic do_req(input logic [31:0] a, input logic [31:0] rd, input int dly,
                          output logic h, output logic [31:0] d, output bit saw);
        int n, fills, ack_n;
        bit done, bad_ready, moved;
        logic [31:0] first_addr;
        h = 1'b0; d = '0; saw = 1'b0; fills = 0; ack_n = 0;
        done = 1'b0; bad_ready = 1'b0; moved = 1'b0; first_addr = '0;
        @(negedge clk);
        req_valid = 1'b1;
        address   = a;
        check("ready_idle", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        address   = $urandom;
        n = 1;
        while (!done && n < 200) begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (resp_valid) begin
                h = hit;
                d = dataOut;
                done = 1'b1;
                if (saw) check("miss_latency", n - ack_n, 1);
                else     check("hit_latency", n, 2);
            end else begin
                if (req_ready) bad_ready = 1'b1;
                if (mem_req) begin
                    if (!saw) begin
                        first_addr = mem_addr;
                        check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
                    end else if (mem_addr !== first_addr) begin
                        moved = 1'b1;
                    end
                    saw = 1'b1;
                    if (fills == dly) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rd;
                        ack_n     = n;
                    end
                    fills++;
                end
                @(negedge clk);
                n++;
            end
        end
        mem_ack = 1'b0;
        check("resp_seen", done, 1);
        check("busy_ready_low", bad_ready, 0);
        if (saw) check("mem_addr_stable", moved, 0);
        @(negedge clk);
        check("resp_pulse_end", resp_valid, 0);
        check("ready_again", req_ready, 1);
    endtask

    // Request checked against the reference model.
    task automatic txn(input logic [31:0] a, input logic [31:0] rd, input int dly);
        logic eh, h;
        logic [31:0] ed, d;
        bit saw;
        model_access(a, rd, eh, ed);
        do_req(a, rd, dly, h, d, saw);
        $display("[TB] req addr=%08h hit=%0d data=%08h acc=%0d miss=%0d (model hit=%0d data=%08h)",
                 a, h, d, access_count, miss_count, eh, ed);
        check("hit", h, eh);
        check("data", d, ed);
        check("mem_req_on_miss", saw, !eh);
        check("access_count", access_count, m_acc);
        check("miss_count", miss_count, m_miss);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        int          dly;
        logic        exp_hit;
        logic [31:0] exp_data;
        int          exp_acc;
        int          exp_miss;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic h, eh;
        logic [31:0] d, ed;
        bit saw;
        int accepts, fills, c;
        bit done, late_ready;

        vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 3, 1'b0, 32'hDEAD_BEEF, 1, 1};
        vecs[1] = '{32'h0000_0010, 32'h0BAD_0BAD, 0, 1'b1, 32'hDEAD_BEEF, 2, 1};
        vecs[2] = '{32'h0000_0013, 32'h0BAD_0BAD, 0, 1'b1, 32'hDEAD_BEEF, 3, 1};
        vecs[3] = '{32'h0000_0050, 32'h1111_1111, 0, 1'b0, 32'h1111_1111, 4, 2};
        vecs[4] = '{32'h0000_0010, 32'hDEAD_BEEF, 1, 1'b0, 32'hDEAD_BEEF, 5, 3};

        // Reset state, asserted from time zero.
        model_reset();
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_hit", hit, 0);
        check("rst_dataOut", dataOut, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_access", access_count, 0);
        check("rst_miss", miss_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: first fill, offset-alias hits, conflict replacement.
        for (int i = 0; i < 5; i++) begin
            model_access(vecs[i].addr, vecs[i].rdata, eh, ed);
            do_req(vecs[i].addr, vecs[i].rdata, vecs[i].dly, h, d, saw);
            $display("[TB] vec %0d addr=%08h hit=%0d data=%08h acc=%0d miss=%0d",
                     i, vecs[i].addr, h, d, access_count, miss_count);
            check("vec_hit", h, vecs[i].exp_hit);
            check("vec_data", d, vecs[i].exp_data);
            check("vec_mem_req", saw, !vecs[i].exp_hit);
            check("vec_access", access_count, vecs[i].exp_acc);
            check("vec_miss", miss_count, vecs[i].exp_miss);
        end

        // Spurious mem_ack while idle: no effect.
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_ack = 1'b0;
        check("spur_resp", resp_valid, 0);
        check("spur_ready", req_ready, 1);
        check("spur_mem_req", mem_req, 0);
        check("spur_access", access_count, m_acc);
        check("spur_miss", miss_count, m_miss);

        // req_valid held for 10 cycles across a slow miss: one accept only.
        model_access(32'h0000_0024, 32'h2424_2424, eh, ed);
        accepts = 0; fills = 0; done = 1'b0; late_ready = 1'b0;
        for (c = 0; c < 60 && !done; c++) begin
            mem_ack = 1'b0;
            req_valid = (c < 10);
            address = 32'h0000_0024;
            if (resp_valid) begin
                done = 1'b1;
                check("hold_hit", hit, eh);
                check("hold_data", dataOut, ed);
            end else begin
                if (req_valid && req_ready) accepts++;
                if (c > 0 && req_ready) late_ready = 1'b1;
                if (mem_req) begin
                    if (fills == 9) begin
                        mem_ack = 1'b1;
                        mem_rdata = 32'h2424_2424;
                    end
                    fills++;
                end
                @(negedge clk);
            end
        end
        req_valid = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        $display("[TB] hold-valid miss accepts=%0d acc=%0d miss=%0d", accepts, access_count, miss_count);
        check("hold_done", done, 1);
        check("hold_accepts", accepts, 1);
        check("hold_ready_low", late_ready, 0);
        check("hold_access", access_count, m_acc);
        check("hold_miss", miss_count, m_miss);

        // Reset in the middle of a fill.
        @(negedge clk);
        req_valid = 1'b1;
        address = 32'h0000_0090;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("midfill_in_fill", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midfill_mem_req", mem_req, 0);
        check("midfill_mem_addr", mem_addr, 0);
        check("midfill_access", access_count, 0);
        check("midfill_miss", miss_count, 0);
        check("midfill_ready", req_ready, 1);
        mem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_resp", resp_valid, 0);
        check("late_ack_mem_req", mem_req, 0);
        check("late_ack_access", access_count, 0);
        $display("[TB] reset mid-fill done");
        txn(32'h0000_0010, 32'hCAFE_F00D, 1);   // previously filled, now misses

        // Reset during RESP cuts the pulse and clears the counters.
        @(negedge clk);
        req_valid = 1'b1;
        address = 32'h0000_0010;
        @(negedge clk);
        req_valid = 1'b0;
        done = 1'b0;
        for (c = 0; c < 10 && !done; c++) begin
            if (resp_valid) done = 1'b1;
            else @(negedge clk);
        end
        check("resp_reached", done, 1);
        #2 rst_n = 1'b0;
        #1;
        check("resp_rst_pulse", resp_valid, 0);
        check("resp_rst_access", access_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        $display("[TB] reset during response done");

        // Miss counter saturation: 20 conflicting misses on one line.
        for (int i = 0; i < 20; i++) begin
            txn(32'(i + 1) << 6 | 32'h4, $urandom, i % 3);
        end
        check("miss_saturated", miss_count, 4'hF);
        check("access_saturated", access_count, 4'hF);

        // Randomised traffic over a small address pool so hits and conflicts mix.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            txn(a, $urandom, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
